// File: rtl/seg7_bcd_scan.sv
// seg7_bcd_scan: N-digit BCD up/down counter with prescaled count tick,
// parallel load and wrap carry, driving a time-multiplexed 7-segment display
// (one digit active per scan slot, seg/an registered together).
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
module seg7_bcd_scan #(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  carry,
  output logic [4*DIGITS-1:0]   value
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]     SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_MASK   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_MASK    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] AN_FIRST   = DIGITS'(1);

  // Active-high segment code {a,b,c,d,e,f,g,dp} for one BCD digit.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hFC;
      4'd1:    code = 8'h60;
      4'd2:    code = 8'hDA;
      4'd3:    code = 8'hF2;
      4'd4:    code = 8'h66;
      4'd5:    code = 8'hB6;
      4'd6:    code = 8'hBE;
      4'd7:    code = 8'hE0;
      4'd8:    code = 8'hFE;
      4'd9:    code = 8'hE6;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_clean;
  logic [PW-1:0]       presc;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic                carry_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   an_r;
  logic                tick;
  logic                wrap;
  logic                propagate;
  logic [3:0]          digit;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [DIGITS-1:0]   an_next;

  assign tick = en && (presc == PRESC_LAST);

  // Ripple the +1 / -1 through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    count_next = count;
    propagate  = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (propagate) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = digit + 4'd1;
            propagate = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[4*i +: 4] = 4'd9;
          end else begin
            count_next[4*i +: 4] = digit - 4'd1;
            propagate = 1'b0;
          end
        end
      end
    end
    wrap = propagate;
  end

  // Non-BCD nibbles in the load value are forced to 0 so the count stays legal.
  always_comb begin
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] <= 4'd9) begin
        load_clean[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // Pick the digit and one-hot select for the current scan slot.
  always_comb begin
    cur_digit = count[3:0];
    an_next   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_digit  = count[4*i +: 4];
        an_next[i] = 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              higher_zero;

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz          = '0;
    higher_zero = 1'b1;
    cur_blank   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (count[4*i +: 4] == 4'd0);
      lz[i] = higher_zero;
    end
    lz[0] = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_blank = lz[i];
      end
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  // Count, prescaler and carry pulse: reset beats load, load beats tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      presc   <= '0;
      carry_r <= 1'b0;
    end else if (load) begin
      count   <= load_clean;
      presc   <= '0;
      carry_r <= 1'b0;
    end else begin
      if (en) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        count   <= count_next;
        carry_r <= wrap;
      end else begin
        carry_r <= 1'b0;
      end
    end
  end

  // Free-running scan slot timer stepping the digit index, independent of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Register seg and an on the same edge so they never disagree at the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= seg_code(4'd0) ^ SEG_MASK;
      an_r  <= AN_FIRST ^ AN_MASK;
    end else begin
      seg_r <= (cur_blank ? 8'h00 : seg_code(cur_digit)) ^ SEG_MASK;
      an_r  <= an_next ^ AN_MASK;
    end
  end

  assign seg   = seg_r;
  assign an    = an_r;
  assign carry = carry_r;
  assign value = count;

endmodule
